// File: rtl/sam_vram_pkg.sv
// Shared types and sizes for the video VRAM read server.
// Holds the server FSM state type and the default address/data widths.
package sam_vram_pkg;

    localparam int VRAM_AW = 19;
    localparam int VRAM_DW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        CPU  = 2'd3
    } vs_state_t;

endpackage

// File: rtl/vram_server.sv
// Serves the video controller's two VRAM read ports over one shared
// 16-bit memory port, filling idle gaps with CPU word accesses.
// Ports:
//   clk_sys, reset          : clock, synchronous active-high reset
//   vram_addr1/2            : video fetch address pair
//   vram_dout1/2            : data of the last completed pair (atomic)
//   vram_late               : pair changed before the previous one landed
//   cpu_req/we/be/addr/wdata: CPU request (level, held until ack)
//   cpu_rdata, cpu_ack      : CPU completion (one-cycle ack)
//   mem_req/we/be/addr/wdata: registered memory request
//   mem_rdata, mem_ack      : memory completion
module vram_server
    import sam_vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic [AW-1:0] vram_addr1,
    input  logic [AW-1:0] vram_addr2,
    output logic [DW-1:0] vram_dout1,
    output logic [DW-1:0] vram_dout2,
    output logic          vram_late,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_be,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          mem_req,
    output logic          mem_we,
    output logic [1:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    vs_state_t     state_q, state_d;
    logic [AW-1:0] la1_q, la1_d;
    logic [AW-1:0] la2_q, la2_d;
    logic          lvalid_q, lvalid_d;
    logic          lflag_q, lflag_d;
    logic [DW-1:0] tmp1_q, tmp1_d;
    logic [DW-1:0] dout1_q, dout1_d;
    logic [DW-1:0] dout2_q, dout2_d;
    logic [DW-1:0] crd_q, crd_d;
    logic          cack_q, cack_d;
    logic          late_q, late_d;
    logic          mreq_q, mreq_d;
    logic          mwe_q, mwe_d;
    logic [1:0]    mbe_q, mbe_d;
    logic [AW-1:0] maddr_q, maddr_d;
    logic [DW-1:0] mwd_q, mwd_d;

    logic moved;
    logic pend;

    assign moved = (vram_addr1 != la1_q) | (vram_addr2 != la2_q);
    assign pend  = !lvalid_q | moved;

    always_comb begin
        state_d  = state_q;
        la1_d    = la1_q;
        la2_d    = la2_q;
        lvalid_d = lvalid_q;
        lflag_d  = lflag_q;
        tmp1_d   = tmp1_q;
        dout1_d  = dout1_q;
        dout2_d  = dout2_q;
        crd_d    = crd_q;
        cack_d   = 1'b0;
        late_d   = 1'b0;
        mreq_d   = mreq_q;
        mwe_d    = mwe_q;
        mbe_d    = mbe_q;
        maddr_d  = maddr_q;
        mwd_d    = mwd_q;

        // One late pulse per latched pair, however often it moves.
        if ((state_q == RD1 || state_q == RD2)
                && moved && !lflag_q) begin
            late_d  = 1'b1;
            lflag_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (pend) begin
                    la1_d   = vram_addr1;
                    la2_d   = vram_addr2;
                    lflag_d = 1'b0;
                    state_d = RD1;
                    mreq_d  = 1'b1;
                    mwe_d   = 1'b0;
                    mbe_d   = 2'b11;
                    maddr_d = vram_addr1;
                end else if (cpu_req) begin
                    state_d = CPU;
                    mreq_d  = 1'b1;
                    mwe_d   = cpu_we;
                    mbe_d   = cpu_we ? cpu_be : 2'b11;
                    maddr_d = cpu_addr;
                    mwd_d   = cpu_wdata;
                end
            end
            RD1: begin
                if (mem_ack) begin
                    tmp1_d  = mem_rdata;
                    state_d = RD2;
                    maddr_d = la2_q;
                end
            end
            RD2: begin
                if (mem_ack) begin
                    if (!moved) begin
                        dout1_d  = tmp1_q;
                        dout2_d  = mem_rdata;
                        lvalid_d = 1'b1;
                        state_d  = IDLE;
                        mreq_d   = 1'b0;
                    end else begin
                        // Stale pair: drop it and chase the new one.
                        la1_d   = vram_addr1;
                        la2_d   = vram_addr2;
                        lflag_d = 1'b0;
                        state_d = RD1;
                        maddr_d = vram_addr1;
                    end
                end
            end
            CPU: begin
                if (mem_ack) begin
                    cack_d  = 1'b1;
                    state_d = IDLE;
                    mreq_d  = 1'b0;
                    if (!mwe_q) begin
                        crd_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q  <= IDLE;
            la1_q    <= '0;
            la2_q    <= '0;
            lvalid_q <= 1'b0;
            lflag_q  <= 1'b0;
            tmp1_q   <= '0;
            dout1_q  <= '0;
            dout2_q  <= '0;
            crd_q    <= '0;
            cack_q   <= 1'b0;
            late_q   <= 1'b0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            mbe_q    <= 2'b11;
            maddr_q  <= '0;
            mwd_q    <= '0;
        end else begin
            state_q  <= state_d;
            la1_q    <= la1_d;
            la2_q    <= la2_d;
            lvalid_q <= lvalid_d;
            lflag_q  <= lflag_d;
            tmp1_q   <= tmp1_d;
            dout1_q  <= dout1_d;
            dout2_q  <= dout2_d;
            crd_q    <= crd_d;
            cack_q   <= cack_d;
            late_q   <= late_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            mbe_q    <= mbe_d;
            maddr_q  <= maddr_d;
            mwd_q    <= mwd_d;
        end
    end

    assign vram_dout1 = dout1_q;
    assign vram_dout2 = dout2_q;
    assign vram_late  = late_q;
    assign cpu_rdata  = crd_q;
    assign cpu_ack    = cack_q;
    assign mem_req    = mreq_q;
    assign mem_we     = mwe_q;
    assign mem_be     = mbe_q;
    assign mem_addr   = maddr_q;
    assign mem_wdata  = mwd_q;

endmodule

// File: tb/tb_vram_server.sv
// Scoreboard bench for vram_server: memory model answers with
// addr[15:0]^16'hA5A5 after two cycles; monitors compare against queues.
module tb_vram_server;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int L  = 2;

    logic          clk_sys = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] vram_addr1, vram_addr2;
    logic [DW-1:0] vram_dout1, vram_dout2;
    logic          vram_late;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [1:0]    cpu_be = 2'b00;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          mem_req, mem_we;
    logic [1:0]    mem_be;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    vram_server dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .vram_addr1(vram_addr1),
        .vram_addr2(vram_addr2),
        .vram_dout1(vram_dout1),
        .vram_dout2(vram_dout2),
        .vram_late (vram_late),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_be    (cpu_be),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc++;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [1:0]    be;
        logic [DW-1:0] wdata;
    } mreq_t;

    typedef struct packed {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } vid_t;

    typedef struct packed {
        logic          chk;
        logic [DW-1:0] d;
    } cpu_t;

    mreq_t exp_mem[$];
    vid_t  exp_vid[$];
    cpu_t  exp_cpu[$];

    task automatic push_rd(input logic [AW-1:0] a);
        mreq_t m;
        m.addr = a; m.we = 1'b0; m.be = 2'b11; m.wdata = '0;
        exp_mem.push_back(m);
    endtask

    // Memory: accepts a request on a falling edge, acks L cycles later.
    int   mem_starts = 0;
    bit   busy = 0;
    int   cnt = 0;
    logic [AW-1:0] cur_addr;

    always @(negedge clk_sys) begin
        mreq_t e;
        if (mem_ack) mem_ack = 1'b0;
        if (busy) begin
            if (cnt <= 1) begin
                mem_ack   = 1'b1;
                mem_rdata = cur_addr[15:0] ^ 16'hA5A5;
                busy      = 0;
            end else begin
                cnt--;
            end
        end else if (mem_req) begin
            busy     = 1;
            cnt      = L;
            cur_addr = mem_addr;
            mem_starts++;
            if (exp_mem.size() == 0) begin
                chk("mem_unexpected", {13'd0, mem_addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_mem.pop_front();
                chk("mem_addr", {13'd0, mem_addr}, {13'd0, e.addr});
                chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
                chk("mem_be", {30'd0, mem_be}, {30'd0, e.be});
                if (e.we) begin
                    chk("mem_wdata", {16'd0, mem_wdata},
                        {16'd0, e.wdata});
                end
            end
        end
    end

    // Output monitor.
    int   late_cnt = 0;
    logic [DW-1:0] p1, p2;
    logic pack_q = 1'b0;
    logic pcack_q = 1'b0;

    always @(negedge clk_sys) begin
        vid_t v;
        cpu_t c;
        #2;
        if (reset) begin
            p1 = vram_dout1;
            p2 = vram_dout2;
        end else begin
            if (vram_dout1 !== p1 || vram_dout2 !== p2) begin
                if (exp_vid.size() == 0) begin
                    chk("vid_unexpected", {vram_dout1, vram_dout2},
                        {p1, p2});
                end else begin
                    v = exp_vid.pop_front();
                    chk("vid_pair", {vram_dout1, vram_dout2},
                        {v.d1, v.d2});
                end
                p1 = vram_dout1;
                p2 = vram_dout2;
            end
            if (cpu_ack) begin
                chk("cpu_ack_after_mem_ack", {31'd0, pack_q}, 32'd1);
                chk("cpu_ack_one_cycle", {31'd0, pcack_q}, 32'd0);
                if (exp_cpu.size() == 0) begin
                    chk("cpu_unexpected", 32'd1, 32'd0);
                end else begin
                    c = exp_cpu.pop_front();
                    if (c.chk) begin
                        chk("cpu_rdata", {16'd0, cpu_rdata},
                            {16'd0, c.d});
                    end
                end
            end
            if (vram_late) late_cnt++;
        end
        pack_q  = mem_ack;
        pcack_q = cpu_ack;
    end

    task automatic wait_pair(input logic [DW-1:0] e1,
                             input logic [DW-1:0] e2,
                             input string nm, output int lat);
        int t0;
        bit ok;
        t0 = cyc;
        ok = 0;
        lat = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_sys); #2;
            if (vram_dout1 === e1 && vram_dout2 === e2) begin
                ok = 1;
                lat = cyc - t0;
                break;
            end
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_req(input logic [AW-1:0] a, input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_sys); #2;
            if (mem_req && mem_addr == a) begin
                ok = 1;
                break;
            end
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_cack(input string nm);
        bit ok;
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk_sys); #2;
            if (cpu_ack) begin
                ok = 1;
                break;
            end
        end
        chk(nm, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=done");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int s;
        mreq_t m;
        cpu_t  c;
        vram_addr1 = 19'h00010;
        vram_addr2 = 19'h00190;
        repeat (3) @(negedge clk_sys);
        #2;
        chk("rst_dout1", {16'd0, vram_dout1}, 32'd0);
        chk("rst_dout2", {16'd0, vram_dout2}, 32'd0);
        chk("rst_cpu_rdata", {16'd0, cpu_rdata}, 32'd0);
        chk("rst_cpu_ack", {31'd0, cpu_ack}, 32'd0);
        chk("rst_late", {31'd0, vram_late}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_be", {30'd0, mem_be}, 32'd3);
        chk("rst_mem_addr", {13'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);

        // First pair straight out of reset.
        push_rd(19'h00010);
        push_rd(19'h00190);
        exp_vid.push_back({16'hA5B5, 16'hA435});
        reset = 1'b0;
        wait_pair(16'hA5B5, 16'hA435, "pair_a", lat);
        // Sampling edge plus 2L+2 cycles.
        chk("pair_a_latency", lat, 32'd7);
        chk("pair_a_late", late_cnt, 32'd0);

        // Stable pair: no traffic, outputs hold.
        s = mem_starts;
        repeat (100) @(negedge clk_sys);
        #2;
        chk("stable_noreq", mem_starts - s, 32'd0);
        chk("stable_hold", {vram_dout1, vram_dout2},
            {16'hA5B5, 16'hA435});

        // Change during RD2: discard and jump to the newest pair.
        push_rd(19'h00020);
        push_rd(19'h00220);
        push_rd(19'h00030);
        push_rd(19'h00330);
        exp_vid.push_back({16'hA595, 16'hA695});
        vram_addr1 = 19'h00020;
        vram_addr2 = 19'h00220;
        wait_req(19'h00220, "rd2_reached");
        vram_addr1 = 19'h00030;
        vram_addr2 = 19'h00330;
        wait_pair(16'hA595, 16'hA695, "pair_c", lat);
        repeat (3) @(negedge clk_sys);
        chk("late_once", late_cnt, 32'd1);

        // CPU write; cpu_rdata keeps its old value.
        m.addr = 19'h12345; m.we = 1'b1;
        m.be = 2'b01; m.wdata = 16'hABCD;
        exp_mem.push_back(m);
        c.chk = 1'b1; c.d = 16'h0000;
        exp_cpu.push_back(c);
        cpu_we = 1'b1; cpu_be = 2'b01;
        cpu_addr = 19'h12345; cpu_wdata = 16'hABCD;
        cpu_req = 1'b1;
        wait_cack("cpu_wr_ack");
        cpu_req = 1'b0;

        // CPU read.
        push_rd(19'h00555);
        c.chk = 1'b1; c.d = 16'hA0F0;
        exp_cpu.push_back(c);
        cpu_we = 1'b0; cpu_be = 2'b00;
        cpu_addr = 19'h00555; cpu_wdata = 16'h0000;
        cpu_req = 1'b1;
        wait_cack("cpu_rd_ack");
        cpu_req = 1'b0;

        // Video and CPU together: video wins.
        push_rd(19'h00040);
        push_rd(19'h00440);
        push_rd(19'h00777);
        exp_vid.push_back({16'hA5E5, 16'hA1E5});
        c.chk = 1'b1; c.d = 16'hA2D2;
        exp_cpu.push_back(c);
        vram_addr1 = 19'h00040;
        vram_addr2 = 19'h00440;
        cpu_addr = 19'h00777;
        cpu_req = 1'b1;
        wait_cack("cpu_after_vid_ack");
        chk("vid_before_cpu", {vram_dout1, vram_dout2},
            {16'hA5E5, 16'hA1E5});
        cpu_req = 1'b0;

        // Equal addresses: still two reads.
        push_rd(19'h00060);
        push_rd(19'h00060);
        exp_vid.push_back({16'hA5C5, 16'hA5C5});
        vram_addr1 = 19'h00060;
        vram_addr2 = 19'h00060;
        wait_pair(16'hA5C5, 16'hA5C5, "pair_equal", lat);

        // Reset while RD1 is outstanding.
        push_rd(19'h00050);
        vram_addr1 = 19'h00050;
        vram_addr2 = 19'h00550;
        wait_req(19'h00050, "rd1_reached");
        reset = 1'b1;
        @(negedge clk_sys); #2;
        chk("rst_mid_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mid_be", {30'd0, mem_be}, 32'd3);
        chk("rst_mid_dout1", {16'd0, vram_dout1}, 32'd0);
        repeat (4) @(negedge clk_sys);
        #2;
        push_rd(19'h00050);
        push_rd(19'h00550);
        exp_vid.push_back({16'hA5F5, 16'hA0F5});
        reset = 1'b0;
        wait_pair(16'hA5F5, 16'hA0F5, "pair_refetch", lat);
        chk("refetch_latency", lat, 32'd7);

        repeat (5) @(negedge clk_sys);
        #3;
        chk("mem_q_empty", exp_mem.size(), 32'd0);
        chk("vid_q_empty", exp_vid.size(), 32'd0);
        chk("cpu_q_empty", exp_cpu.size(), 32'd0);
        chk("late_total", late_cnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
